// File: rtl/module_scan_teclado_if.sv
// Keypad link between the scan controller and the keypad/consumer side.
// Port summary: row (keypad rows, active-low), column (one-hot active-low drive),
//               key_code / key_valid / key_held (accepted-key result).
interface module_scan_teclado_if;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Scan controller side.
  modport master (
    input  row,
    output column,
    output key_code,
    output key_valid,
    output key_held
  );

  // Keypad / operand-capture side.
  modport slave (
    output row,
    input  column,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/module_scan_teclado.sv
// 4x4 keypad scan controller: one column driven low at a time, rows synchronized,
// press and release debounced, one-cycle key_valid strobe with a 4-bit key code.
// Latency: strobe DEBOUNCE_CYCLES cycles after the press debounce starts; no backpressure.
// Ports: clk, rst (async, active-high), kp.master (row in; column, key_code,
//        key_valid, key_held out).
// Optional: define TECLADO_REPEAT_EN to re-strobe every REPEAT_CYCLES while held.
module module_scan_teclado #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_CYCLES   = 13500000
) (
  input  logic                   clk,
  input  logic                   rst,
  module_scan_teclado_if.master  kp
);

  typedef enum logic [1:0] {SCAN = 2'd0, DEB_PRESS = 2'd1, HELD = 2'd2} state_t;

  // One shared counter: settle in SCAN, press debounce, release debounce.
  localparam int CMAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TC    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX - 1);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("module_scan_teclado: cycle parameters must be at least 1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]    col_idx, col_nxt;
  logic [3:0]    pat, pat_nxt;
  logic [3:0]    row_meta, rs;
  logic [3:0]    key_code_q, code_nxt;
  logic          key_valid_q, valid_nxt;
  logic          key_held_q, held_nxt;
  logic          accept, release_done;
  logic [3:0]    column_c;

  // Lowest active row wins when several rows are low.
  function automatic logic [3:0] key_map(input logic [3:0] p, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] code;
    r = !p[0] ? 2'd0 : !p[1] ? 2'd1 : !p[2] ? 2'd2 : 2'd3;
    case ({r, c})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
      4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk; everything below looks only at rs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= kp.row;
      rs       <= row_meta;
    end
  end

`ifdef TECLADO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_TC = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt, rpt_nxt;
  logic          rpt_fire;

  // Repeat timer runs only while the exact accepted pattern is still present.
  always_comb begin
    rpt_nxt  = '0;
    rpt_fire = 1'b0;
    if (state == HELD && rs == pat) begin
      if (rpt == RPT_TC) rpt_fire = 1'b1;
      else               rpt_nxt  = rpt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt <= '0;
    else     rpt <= rpt_nxt;
  end
`endif

  // State register (plus datapath registers updated from the comb processes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= 2'd0;
      pat         <= 4'hF;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      col_idx     <= col_nxt;
      pat         <= pat_nxt;
      key_code_q  <= code_nxt;
      key_valid_q <= valid_nxt;
      key_held_q  <= held_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    col_nxt      = col_idx;
    pat_nxt      = pat;
    accept       = 1'b0;
    release_done = 1'b0;
    cnt_inc      = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    cnt_nxt      = cnt_inc;
    case (state)
      SCAN: begin
        if (cnt == SETTLE_TC) begin
          cnt_nxt = '0;
          if (rs == 4'hF) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            pat_nxt   = rs;
            state_nxt = DEB_PRESS;
          end
        end
      end
      DEB_PRESS: begin
        if (rs != pat) begin
          // Bounce: rescan the same column from a fresh settle count.
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end else if (cnt == DEB_TC) begin
          cnt_nxt   = '0;
          accept    = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        // Any non-idle row (including a second key) restarts the release debounce.
        if (rs != 4'hF) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_TC) begin
          cnt_nxt      = '0;
          col_nxt      = col_idx + 2'd1;
          release_done = 1'b1;
          state_nxt    = SCAN;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = SCAN;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    column_c  = ~(4'b0001 << col_idx);
    code_nxt  = key_code_q;
    valid_nxt = 1'b0;
    held_nxt  = key_held_q;
    if (accept) begin
      code_nxt  = key_map(pat, col_idx);
      valid_nxt = 1'b1;
      held_nxt  = 1'b1;
    end
    if (release_done) held_nxt = 1'b0;
`ifdef TECLADO_REPEAT_EN
    if (rpt_fire) valid_nxt = 1'b1;
`endif
  end

  assign kp.column    = column_c;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_module_scan_teclado.sv
// Directed bench for module_scan_teclado with a behavioural 4x4 keypad model.
// Ports driven: clk, rst, kp.row (from pressed-key mask and current column).
module tb_module_scan_teclado;
  localparam int S = 4;
  localparam int D = 8;
  localparam int R = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down

  int n_chk    = 0;
  int n_pass   = 0;
  int n_strobe = 0;
  int n_double = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  module_scan_teclado_if kp ();

  module_scan_teclado #(
    .SETTLE_CYCLES   (S),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[i*4+j] && !col[j]) r[i] = 1'b0;
    return r;
  endfunction

  assign kp.row = keypad_rows(pressed, kp.column);

  // Strobe monitor: counts pulses and back-to-back strobes.
  always @(negedge clk) begin
    if (kp.key_valid) n_strobe++;
    if (kp.key_valid && prev_valid) n_double++;
    prev_valid = kp.key_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Main thread samples and drives just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int n = 0;
    while (!kp.key_valid && n < budget) begin step(); n++; end
    if (!kp.key_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] c, input int budget);
    int n = 0;
    while (kp.column != c && n < budget) begin step(); n++; end
    if (kp.column != c) check({tag, "_timeout"}, int'(kp.column), int'(c));
  endtask

  task automatic wait_drop(input string tag, input int budget);
    int n = 0;
    while (kp.key_held && n < budget) begin step(); n++; end
    check(tag, int'(kp.key_held), 0);
  endtask

  initial begin
    int base, n, bad, code_at, held_at, col_at, seen;
    logic [3:0] exp_col;

    pressed = '0;
    rst     = 1'b1;
    repeat (3) step();
    check("rst_column", int'(kp.column), 4'b1110);
    check("rst_code",   int'(kp.key_code), 0);
    check("rst_valid",  int'(kp.key_valid), 0);
    check("rst_held",   int'(kp.key_held), 0);

    // Idle scan: this cycle is settle count 0 of column 0.
    rst  = 1'b0;
    base = n_strobe;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      exp_col = ~(4'b0001 << (i / 4));
      check($sformatf("scan_col_%0d", i), int'(kp.column), int'(exp_col));
    end
    check("scan_no_strobe", n_strobe - base, 0);

    // "5": row1/col1, held 40 cycles.
    base = n_strobe; seen = 0; bad = 0; code_at = -1; held_at = -1; col_at = -1;
    pressed[5] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (kp.key_valid) begin
        seen = 1; code_at = int'(kp.key_code); held_at = int'(kp.key_held); col_at = int'(kp.column);
      end else if (seen && kp.column != 4'b1101) bad++;
    end
    check("k5_strobes", n_strobe - base, 1);
    check("k5_code", code_at, 5);
    check("k5_held", held_at, 1);
    check("k5_col", col_at, 4'b1101);
    // Release: 2 sync cycles + 8 idle debounce cycles with key_held still 1.
    pressed = '0;
    n = 0;
    while (kp.key_held && n < 50) begin
      n++;
      if (kp.column != 4'b1101) bad++;
      step();
    end
    check("k5_release_cycles", n, 10);
    check("k5_col_frozen_errs", bad, 0);
    check("k5_col_after", int'(kp.column), 4'b1011);
    check("k5_code_kept", int'(kp.key_code), 5);

    // "A": row0/col3 bouncing every 3 cycles, then stable.
    base = n_strobe;
    for (int i = 0; i < 30; i++) begin
      pressed[3] = ((i / 3) % 2 == 0);
      step();
    end
    check("kA_bounce_no_strobe", n_strobe - base, 0);
    pressed[3] = 1'b1;
    wait_strobe("kA", 40);
    check("kA_code", int'(kp.key_code), 10);
    repeat (5) step();
    check("kA_strobes", n_strobe - base, 1);
    pressed = '0;
    wait_drop("kA_drop", 30);

    // "7" with a 5-cycle release glitch while held.
    base = n_strobe;
    pressed[8] = 1'b1;
    wait_strobe("k7", 40);
    check("k7_code", int'(kp.key_code), 7);
    repeat (3) step();
    pressed = '0;
    repeat (5) step();
    pressed[8] = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (!kp.key_held) bad++;
    end
    check("k7_glitch_held_drops", bad, 0);
    check("k7_strobes", n_strobe - base, 1);
    pressed = '0;
    wait_drop("k7_drop", 30);

    // Rows 0 and 2 on column 1: "2" beats "8".
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    wait_strobe("k2", 40);
    check("multi_row_code", int'(kp.key_code), 2);
    pressed = '0;
    wait_drop("k2_drop", 30);

    // "3" press latency from the first cycle column 2 is driven:
    // rows visible after 2 sync cycles, settle ends at 4, debounce 8 -> 12.
    wait_col("k3_c3", 4'b0111, 40);
    pressed[2] = 1'b1;
    wait_col("k3_c2", 4'b1011, 40);
    n = 0;
    while (!kp.key_valid && n < 40) begin step(); n++; end
    check("k3_latency", n, 12);
    check("k3_code", int'(kp.key_code), 3);
    pressed = '0;
    wait_drop("k3_drop", 30);

    // Reset in the middle of the press debounce of "3".
    wait_col("rst_c3", 4'b0111, 40);
    pressed[2] = 1'b1;
    wait_col("rst_c2", 4'b1011, 40);
    base = n_strobe;
    repeat (7) step();
    check("deb_no_strobe_yet", n_strobe - base, 0);
    rst = 1'b1;
    step();
    check("midrst_column", int'(kp.column), 4'b1110);
    check("midrst_code",   int'(kp.key_code), 0);
    check("midrst_valid",  int'(kp.key_valid), 0);
    check("midrst_held",   int'(kp.key_held), 0);
    repeat (2) step();
    pressed = '0;
    step();
    rst = 1'b0;
    repeat (30) step();
    check("midrst_no_strobe", n_strobe - base, 0);

    // "B" held 70 cycles past its strobe.
    pressed[7] = 1'b1;
    wait_strobe("kB", 40);
    check("kB_code", int'(kp.key_code), 11);
    base = n_strobe;
    repeat (70) step();
`ifdef TECLADO_REPEAT_EN
    check("kB_repeats", n_strobe - base, 3);
`else
    check("kB_repeats", n_strobe - base, 0);
`endif
    check("kB_code_after", int'(kp.key_code), 11);
    pressed = '0;
    wait_drop("kB_drop", 30);

    check("no_double_strobe", n_double, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
